// File: rtl/ascon_finalization.sv
// ascon_finalization: AEAD128 finalization. Mixes the key into x2/x3, runs one
// p12 on the shared external core, and forms the 128-bit tag from x3/x4 ^ key.
// Ports: clk, rst (async, active-high); start, key, x0_in..x4_in, tag_exp in;
//   busy, done, err, tag, tag_ok out; perm_start, perm_x0_i..perm_x4_i to the
//   p12 core; perm_done, perm_x0_o..perm_x4_o back from it.
// Param PERM_TIMEOUT: max WAIT cycles before abort with err (0 = no timeout).
// Macro ASCON_FINAL_VERIFY_EN: register tag_exp and drive tag_ok = (tag == tag_exp).
module ascon_finalization #(
  parameter int PERM_TIMEOUT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [63:0]  x0_in,
  input  logic [63:0]  x1_in,
  input  logic [63:0]  x2_in,
  input  logic [63:0]  x3_in,
  input  logic [63:0]  x4_in,
  input  logic [127:0] tag_exp,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [127:0] tag,
  output logic         tag_ok,
  output logic         perm_start,
  output logic [63:0]  perm_x0_i,
  output logic [63:0]  perm_x1_i,
  output logic [63:0]  perm_x2_i,
  output logic [63:0]  perm_x3_i,
  output logic [63:0]  perm_x4_i,
  input  logic         perm_done,
  input  logic [63:0]  perm_x0_o,
  input  logic [63:0]  perm_x1_o,
  input  logic [63:0]  perm_x2_o,
  input  logic [63:0]  perm_x3_o,
  input  logic [63:0]  perm_x4_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  localparam int CW = (PERM_TIMEOUT > 1) ? $clog2(PERM_TIMEOUT) : 1;

  state_e            st_q, st_d;
  logic [4:0][63:0]  s_q, s_d;
  logic [127:0]      key_q, key_d;
  logic [127:0]      tag_q, tag_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [127:0]      tag_new;
  logic              ok_new;

  // Only x3/x4 of the p12 result contribute to the tag.
  logic unused_perm;
  assign unused_perm = ^{perm_x0_o, perm_x1_o, perm_x2_o};

  assign tag_new = {perm_x3_o ^ key_q[127:64], perm_x4_o ^ key_q[63:0]};

`ifdef ASCON_FINAL_VERIFY_EN
  logic [127:0] texp_q, texp_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) texp_q <= '0;
    else     texp_q <= texp_d;
  end

  always_comb begin
    texp_d = texp_q;
    if (st_q == IDLE && start) texp_d = tag_exp;
  end

  assign ok_new = (tag_new == texp_q);
`else
  logic unused_texp;
  assign unused_texp = ^tag_exp;
  assign ok_new      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= IDLE;
      s_q   <= '0;
      key_q <= '0;
      tag_q <= '0;
      ok_q  <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      s_q   <= s_d;
      key_q <= key_d;
      tag_q <= tag_d;
      ok_q  <= ok_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    s_d   = s_q;
    key_d = key_q;
    tag_d = tag_q;
    ok_d  = ok_q;
    err_d = 1'b0;
    cnt_d = cnt_q;
    unique case (st_q)
      IDLE: begin
        if (start) begin
          s_d   = {x4_in, x3_in ^ key[63:0],
                   x2_in ^ key[127:64], x1_in, x0_in};
          key_d = key;
          st_d  = REQ;
        end
      end
      REQ: begin
        cnt_d = '0;
        st_d  = WAIT;
      end
      WAIT: begin
        if (perm_done) begin
          tag_d = tag_new;
          ok_d  = ok_new;
          st_d  = DONE;
        end else if (PERM_TIMEOUT != 0) begin
          // cnt_q counts WAIT cycles already spent without perm_done.
          if (cnt_q == CW'(PERM_TIMEOUT - 1)) begin
            err_d = 1'b1;
            st_d  = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  assign busy       = (st_q != IDLE);
  assign done       = (st_q == DONE);
  assign perm_start = (st_q == REQ);
  assign err        = err_q;
  assign tag        = tag_q;
  assign tag_ok     = ok_q;
  assign perm_x0_i  = s_q[0];
  assign perm_x1_i  = s_q[1];
  assign perm_x2_i  = s_q[2];
  assign perm_x3_i  = s_q[3];
  assign perm_x4_i  = s_q[4];

endmodule
